imem_program_loader: RTL and testbench

//  Boot-time sequencer that streams encoded RV32I instruction words into instruction memory while holding the core in reset.

---
 rtl/imem_program_loader.sv | 131 +++++++++++++
 tb/tb_imem_program_loader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_program_loader.sv
// Boot-time loader: streams program words into imem from address 0, pads the rest with NOPs,
// and holds the core in reset until a complete, well-formed load has finished.
module imem_program_loader #(
  parameter int unsigned            ADDR_WIDTH = 10,
  parameter int unsigned            DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0]  NOP_INSTR  = DATA_WIDTH'(32'h0000_0013)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH:0]   i_prog_len,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  s_ready,
  output logic                  o_imem_we,
  output logic [ADDR_WIDTH-1:0] o_imem_addr,
  output logic [DATA_WIDTH-1:0] o_imem_wdata,
  output logic                  o_cpu_rst,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);

  localparam logic [ADDR_WIDTH:0] Depth = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] One   = {{ADDR_WIDTH{1'b0}}, 1'b1};

  typedef enum logic [2:0] {StIdle, StLoad, StFill, StRun, StErr} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  cpu_rst_q, cpu_rst_d;
  logic                  busy_q, done_q, err_q;

  logic start_ok;
  logic last_idx;
  logic handshake;

  assign s_ready   = (state_q == StLoad);
  assign handshake = s_valid && s_ready;
  assign start_ok  = (i_prog_len != '0) && (i_prog_len <= Depth);
  assign last_idx  = (cnt_q == len_q - One);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      StIdle, StRun, StErr: begin
        if (i_start) begin
          if (start_ok) begin
            state_d = StLoad;
            cnt_d   = '0;
            len_d   = i_prog_len;
          end else begin
            state_d = StErr;
          end
        end
      end
      StLoad: begin
        if (handshake) begin
          we_d    = 1'b1;
          addr_d  = cnt_q[ADDR_WIDTH-1:0];
          wdata_d = s_data;
          cnt_d   = cnt_q + One;
          // A malformed framing still commits the offending word before erroring out.
          if (s_last && last_idx) begin
            state_d = (len_q == Depth) ? StRun : StFill;
          end else if (s_last || last_idx) begin
            state_d = StErr;
          end
        end
      end
      StFill: begin
        we_d    = 1'b1;
        addr_d  = cnt_q[ADDR_WIDTH-1:0];
        wdata_d = NOP_INSTR;
        cnt_d   = cnt_q + One;
        if (cnt_q == Depth - One) begin
          state_d = StRun;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Core reset drops only once RUN has been held for a cycle, i.e. after the last write lands.
  assign cpu_rst_d = !((state_q == StRun) && (state_d == StRun));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      len_q     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cpu_rst_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cpu_rst_q <= cpu_rst_d;
      busy_q    <= (state_d == StLoad) || (state_d == StFill);
      done_q    <= (state_d == StRun);
      err_q     <= (state_d == StErr);
    end
  end

  assign o_imem_we    = we_q;
  assign o_imem_addr  = addr_q;
  assign o_imem_wdata = wdata_q;
  assign o_cpu_rst    = cpu_rst_q;
  assign o_busy       = busy_q;
  assign o_done       = done_q;
  assign o_err        = err_q;

endmodule

// File: tb/tb_imem_program_loader.sv
// Scoreboard bench for imem_program_loader at DEPTH=16: expected imem writes are queued by the
// stimulus and popped by a write monitor; status outputs are checked directly.
module tb_imem_program_loader;

  localparam int unsigned AW  = 4;
  localparam int unsigned DW  = 32;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic          i_start;
  logic [AW:0]   i_prog_len;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_last;
  logic          s_ready;
  logic          o_imem_we;
  logic [AW-1:0] o_imem_addr;
  logic [DW-1:0] o_imem_wdata;
  logic          o_cpu_rst;
  logic          o_busy;
  logic          o_done;
  logic          o_err;

  imem_program_loader #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .NOP_INSTR (NOP)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_start     (i_start),
    .i_prog_len  (i_prog_len),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_last      (s_last),
    .s_ready     (s_ready),
    .o_imem_we   (o_imem_we),
    .o_imem_addr (o_imem_addr),
    .o_imem_wdata(o_imem_wdata),
    .o_cpu_rst   (o_cpu_rst),
    .o_busy      (o_busy),
    .o_done      (o_done),
    .o_err       (o_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Write monitor: every imem write must match the oldest expected write.
  always @(negedge i_clk) begin
    if (o_imem_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write_addr", 32'(o_imem_addr), 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("write_addr", 32'(o_imem_addr), 32'(e.addr));
        check("write_data", o_imem_wdata, e.data);
      end
    end
  end

  task automatic push(input int a, input logic [31:0] d);
    wr_t e;
    e.addr = a[AW-1:0];
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic push_nops(input int from, input int to);
    for (int a = from; a <= to; a++) push(a, NOP);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_start(input int len);
    i_start    = 1'b1;
    i_prog_len = len[AW:0];
    tick();
    i_start    = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input bit last);
    int n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    while (!s_ready && n < 20) begin
      tick();
      n++;
    end
    check("s_ready_before_send", 32'(s_ready), 32'd1);
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // which: 0 waits for o_done, 1 waits for o_err; expiry counts as a failed comparison.
  task automatic wait_flag(input int which, input string name);
    int n = 0;
    while (((which == 0) ? !o_done : !o_err) && n < 60) begin
      tick();
      n++;
    end
    check(name, 32'((which == 0) ? o_done : o_err), 32'd1);
  endtask

  logic [31:0] prog1 [3];
  logic [31:0] prog6 [16];

  initial begin
    prog1[0] = 32'h0050_0093;
    prog1[1] = 32'h0070_0113;
    prog1[2] = 32'h0020_81B3;
    for (int i = 0; i < 16; i++) prog6[i] = 32'h1000_0000 + 32'(i * 17);

    i_rst = 1'b1; i_start = 1'b0; i_prog_len = '0;
    s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    repeat (3) tick();
    check("rst_we", 32'(o_imem_we), 0);
    check("rst_addr", 32'(o_imem_addr), 0);
    check("rst_wdata", o_imem_wdata, 0);
    check("rst_cpu_rst", 32'(o_cpu_rst), 1);
    check("rst_s_ready", 32'(s_ready), 0);
    check("rst_flags", {29'd0, o_busy, o_done, o_err}, 0);
    i_rst = 1'b0;
    tick();

    // 1. normal load of three words, NOP padding to the top
    for (int i = 0; i < 3; i++) push(i, prog1[i]);
    push_nops(3, 15);
    do_start(3);
    check("t1_busy", 32'(o_busy), 1);
    for (int i = 0; i < 3; i++) send(prog1[i], i == 2);
    wait_flag(0, "t1_done");
    check("t1_last_addr", 32'(o_imem_addr), 15);
    check("t1_cpu_rst_at_last_write", 32'(o_cpu_rst), 1);
    tick();
    check("t1_cpu_rst_released", 32'(o_cpu_rst), 0);
    check("t1_q_empty", exp_q.size(), 0);

    // 2. reload from RUN with alternating valid, prog_len=4
    for (int i = 0; i < 4; i++) push(i, 32'hA000_0000 + 32'(i));
    push_nops(4, 15);
    do_start(4);
    check("t2_cpu_rst_reasserted", 32'(o_cpu_rst), 1);
    for (int i = 0; i < 4; i++) begin
      send(32'hA000_0000 + 32'(i), i == 3);
      if (i < 3) begin
        tick();
        check("t2_gap_we", 32'(o_imem_we), 0);
      end
    end
    wait_flag(0, "t2_done");
    tick();
    check("t2_q_empty", exp_q.size(), 0);

    // 3. s_last on word index 1 of a 4-word program
    push(0, 32'hB000_0000);
    push(1, 32'hB000_0001);
    do_start(4);
    send(32'hB000_0000, 1'b0);
    send(32'hB000_0001, 1'b1);
    wait_flag(1, "t3_err");
    repeat (5) tick();
    check("t3_err_held", 32'(o_err), 1);
    check("t3_cpu_rst", 32'(o_cpu_rst), 1);
    check("t3_s_ready", 32'(s_ready), 0);
    check("t3_q_empty", exp_q.size(), 0);

    // 4. illegal lengths, then a legal 2-word load out of ERR
    do_start(0);
    check("t4_len0_err", 32'(o_err), 1);
    check("t4_len0_busy", 32'(o_busy), 0);
    do_start(17);
    check("t4_len17_err", 32'(o_err), 1);
    push(0, 32'hC000_0000);
    push(1, 32'hC000_0001);
    push_nops(2, 15);
    do_start(2);
    check("t4_busy", 32'(o_busy), 1);
    check("t4_err_cleared", 32'(o_err), 0);
    send(32'hC000_0000, 1'b0);
    send(32'hC000_0001, 1'b1);
    wait_flag(0, "t4_done");
    tick();
    check("t4_cpu_rst_released", 32'(o_cpu_rst), 0);

    // 5. reset while the FILL write to address 7 is on the port
    for (int i = 0; i < 3; i++) push(i, prog1[i]);
    push_nops(3, 7);
    do_start(3);
    for (int i = 0; i < 3; i++) send(prog1[i], i == 2);
    for (int n = 0; n < 30 && !(o_imem_we && o_imem_addr == 4'd7); n++) tick();
    check("t5_at_addr7", 32'(o_imem_addr), 7);
    i_rst = 1'b1;
    tick();
    check("t5_we", 32'(o_imem_we), 0);
    check("t5_cpu_rst", 32'(o_cpu_rst), 1);
    check("t5_s_ready", 32'(s_ready), 0);
    check("t5_flags", {29'd0, o_busy, o_done, o_err}, 0);
    i_rst = 1'b0;
    tick();
    check("t5_q_empty", exp_q.size(), 0);

    // 6. reach RUN, then reload a full 16-word program with no FILL phase
    push(0, 32'hD000_0000);
    push_nops(1, 15);
    do_start(1);
    send(32'hD000_0000, 1'b1);
    wait_flag(0, "t6_first_done");
    tick();
    for (int i = 0; i < 16; i++) push(i, prog6[i]);
    do_start(16);
    check("t6_cpu_rst_reasserted", 32'(o_cpu_rst), 1);
    for (int i = 0; i < 16; i++) send(prog6[i], i == 15);
    wait_flag(0, "t6_done");
    check("t6_cpu_rst_at_last_write", 32'(o_cpu_rst), 1);
    tick();
    check("t6_cpu_rst_released", 32'(o_cpu_rst), 0);
    repeat (4) tick();
    check("t6_q_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
